// File: rtl/sensor_conditioner.sv
`timescale 1ns/1ps
// sensor_conditioner: synchronises and debounces the raw irrigation sensors,
// validates the tank level triple, and presents clean registered outputs.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   h_raw, m_raw, l_raw        raw tank level sensors (1 = water at that height)
//   us_raw, ua_raw, t_raw      raw soil, air-humidity, temperature sensors
//   selector_raw               raw display-mode switch
//   h, m, l                    validated level outputs (hold last valid code)
//   us, ua, t, selector        debounced sensor outputs
//   sensor_fault               level triple inconsistent for FAULT_CYCLES clocks
//   change_pulse               one-cycle strobe when any output changes
module sensor_conditioner #(
  parameter int unsigned DB_CYCLES    = 50000,
  parameter int unsigned FAULT_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic h_raw,
  input  logic m_raw,
  input  logic l_raw,
  input  logic us_raw,
  input  logic ua_raw,
  input  logic t_raw,
  input  logic selector_raw,
  output logic h,
  output logic m,
  output logic l,
  output logic us,
  output logic ua,
  output logic t,
  output logic selector,
  output logic sensor_fault,
  output logic change_pulse
);

  localparam int unsigned N_IN    = 7;
  localparam int unsigned DB_W    = $clog2(DB_CYCLES + 1);
  localparam int unsigned FAULT_W = $clog2(FAULT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

  // Bit order: [6]=h [5]=m [4]=l [3]=us [2]=ua [1]=t [0]=selector
  logic [N_IN-1:0] raw_vec;
  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;
  logic [N_IN-1:0] deb;
  logic [DB_W-1:0] db_cnt [N_IN];

  state_t             state;
  state_t             state_next;
  logic [FAULT_W-1:0] fcnt;
  logic [FAULT_W-1:0] fcnt_next;
  logic [2:0]         lvl_q;
  logic [2:0]         lvl_next;
  logic               fault_q;
  logic               fault_next;
  logic [3:0]         sens_q;
  logic               pulse_q;
  logic               code_ok;

  assign raw_vec = {h_raw, m_raw, l_raw, us_raw, ua_raw, t_raw, selector_raw};

  // Physically possible fill levels: water can only be present from the bottom up.
  function automatic logic level_valid(input logic [2:0] code);
    case (code)
      3'b000, 3'b001, 3'b011, 3'b111: level_valid = 1'b1;
      default:                        level_valid = 1'b0;
    endcase
  endfunction

  // Two-flop synchronisers for all raw inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_vec;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: deb follows sync only after DB_CYCLES consecutive differing clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < int'(N_IN); i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_IN); i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          deb[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Level FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OK;
    else        state <= state_next;
  end

  // Level FSM next-state and output logic.
  always_comb begin
    state_next = state;
    fcnt_next  = fcnt;
    lvl_next   = lvl_q;
    fault_next = fault_q;
    code_ok    = level_valid(deb[6:4]);
    case (state)
      ST_OK: begin
        if (code_ok) begin
          lvl_next  = deb[6:4];
          fcnt_next = '0;
        end else begin
          state_next = ST_SUSPECT;
          fcnt_next  = FAULT_W'(1);
        end
      end
      ST_SUSPECT: begin
        if (code_ok) begin
          // Outputs reload on the following edge once back in OK.
          state_next = ST_OK;
          fcnt_next  = '0;
        end else begin
          fcnt_next = fcnt + FAULT_W'(1);
          if (fcnt >= FAULT_W'(FAULT_CYCLES - 1)) begin
            state_next = ST_FAULT;
            fault_next = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        if (code_ok) begin
          state_next = ST_OK;
          fault_next = 1'b0;
          lvl_next   = deb[6:4];
          fcnt_next  = '0;
        end
      end
      default: begin
        state_next = ST_OK;
      end
    endcase
  end

  // Output registers; change_pulse compares the values about to load with those held now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt    <= '0;
      lvl_q   <= '0;
      fault_q <= 1'b0;
      sens_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      fcnt    <= fcnt_next;
      lvl_q   <= lvl_next;
      fault_q <= fault_next;
      sens_q  <= deb[3:0];
      pulse_q <= ({lvl_next, deb[3:0], fault_next} != {lvl_q, sens_q, fault_q});
    end
  end

  assign h            = lvl_q[2];
  assign m            = lvl_q[1];
  assign l            = lvl_q[0];
  assign us           = sens_q[3];
  assign ua           = sens_q[2];
  assign t            = sens_q[1];
  assign selector     = sens_q[0];
  assign sensor_fault = fault_q;
  assign change_pulse = pulse_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
`timescale 1ns/1ps
// Testbench for sensor_conditioner: directed scenarios plus random raw input
// segments, checked every cycle against a rule-level reference model.
module tb_sensor_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned FC = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] raw   = '0;   // [6]=h [5]=m [4]=l [3]=us [2]=ua [1]=t [0]=selector

  logic h, m, l, us, ua, t, selector, sensor_fault, change_pulse;
  logic [8:0] obs;
  assign obs = {h, m, l, us, ua, t, selector, sensor_fault, change_pulse};

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  bit fault_seen = 1'b0;

  always #5 clk = ~clk;

  sensor_conditioner #(.DB_CYCLES(DB), .FAULT_CYCLES(FC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .h_raw        (raw[6]),
    .m_raw        (raw[5]),
    .l_raw        (raw[4]),
    .us_raw       (raw[3]),
    .ua_raw       (raw[2]),
    .t_raw        (raw[1]),
    .selector_raw (raw[0]),
    .h            (h),
    .m            (m),
    .l            (l),
    .us           (us),
    .ua           (ua),
    .t            (t),
    .selector     (selector),
    .sensor_fault (sensor_fault),
    .change_pulse (change_pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Reference model: raw is seen two edges late; a debounced bit flips once the
  // last DB seen samples all disagree with it; level outputs follow the rules
  // on runs of invalid codes.
  logic [6:0] m_s1, m_s2, m_deb;
  logic [6:0] win[$];
  int         inv_run;
  logic       m_fault, m_prev_valid, m_pulse;
  logic [2:0] m_lvl;
  logic [7:0] m_out;

  always @(posedge clk or negedge rst_n) begin : model
    logic [6:0] deb_old;
    logic [2:0] code;
    logic       v, load, all_diff;
    logic [7:0] out_new;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_deb = '0; win.delete();
      inv_run = 0; m_fault = 1'b0; m_prev_valid = 1'b1;
      m_lvl = '0; m_out = '0; m_pulse = 1'b0;
    end else begin
      deb_old = m_deb;
      win.push_back(m_s2);
      if (win.size() > int'(DB)) void'(win.pop_front());
      if (win.size() == int'(DB)) begin
        for (int i = 0; i < 7; i++) begin
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) m_deb[i] = ~m_deb[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      code = deb_old[6:4];
      v    = code inside {3'b000, 3'b001, 3'b011, 3'b111};
      load = v && (m_prev_valid || m_fault);
      if (v) begin
        if (load) m_lvl = code;
        inv_run = 0;
        m_fault = 1'b0;
      end else begin
        inv_run++;
        if (inv_run >= int'(FC)) m_fault = 1'b1;
      end
      m_prev_valid = v;
      out_new = {m_lvl, deb_old[3:0], m_fault};
      m_pulse = (out_new != m_out);
      m_out   = out_new;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("cycle", 32'(obs), 32'({m_out, m_pulse}));
      if (change_pulse) pulse_cnt++;
      if (sensor_fault) fault_seen = 1'b1;
    end
  end

  initial begin
    int p0;
    int n;

    rst_n = 1'b0;
    raw   = '0;
    step(3);
    check("reset_out", 32'(obs), 32'(0));
    rst_n = 1'b1;

    // Idle
    p0 = pulse_cnt;
    step(20);
    check("idle_out", 32'(obs), 32'(0));
    check("idle_pulses", 32'(pulse_cnt - p0), 32'(0));

    // us latency and pulse
    raw[3] = 1'b1;
    step(6);
    check("us_before", 32'(us), 32'(0));
    step(1);
    check("us_rise", 32'(us), 32'(1));
    check("us_pulse", 32'(change_pulse), 32'(1));
    step(1);
    check("us_pulse_once", 32'(change_pulse), 32'(0));

    // Short glitch is filtered
    raw[3] = 1'b0;
    step(10);
    p0 = pulse_cnt;
    raw[3] = 1'b1;
    step(3);
    raw[3] = 1'b0;
    step(12);
    check("glitch_us", 32'(us), 32'(0));
    check("glitch_pulses", 32'(pulse_cnt - p0), 32'(0));

    // Fill sequence
    p0 = pulse_cnt;
    fault_seen = 1'b0;
    raw[4] = 1'b1;
    step(10);
    check("fill_001", 32'({h, m, l}), 32'(3'b001));
    raw[5] = 1'b1;
    step(10);
    check("fill_011", 32'({h, m, l}), 32'(3'b011));
    raw[6] = 1'b1;
    step(10);
    check("fill_111", 32'({h, m, l}), 32'(3'b111));
    check("fill_pulses", 32'(pulse_cnt - p0), 32'(3));
    check("fill_fault", 32'(fault_seen), 32'(0));

    // Brief invalid code held off by SUSPECT
    raw[6:4] = 3'b001;
    step(10);
    check("back_001", 32'({h, m, l}), 32'(3'b001));
    fault_seen = 1'b0;
    raw[6:4] = 3'b010;
    step(5);
    raw[6:4] = 3'b011;
    step(3);
    check("hold_001", 32'({h, m, l}), 32'(3'b001));
    step(12);
    check("recover_011", 32'({h, m, l}), 32'(3'b011));
    check("brief_no_fault", 32'(fault_seen), 32'(0));

    // Persistent invalid code raises fault, valid code clears it
    raw[6:4] = 3'b101;
    n = 0;
    while (!sensor_fault && n < 40) begin
      step(1);
      n++;
    end
    check("fault_latency", 32'(n), 32'(14));
    check("fault_hold", 32'({h, m, l}), 32'(3'b011));
    step(4);
    p0 = pulse_cnt;
    raw[6:4] = 3'b111;
    step(10);
    check("fault_clear", 32'(sensor_fault), 32'(0));
    check("clear_lvl", 32'({h, m, l}), 32'(3'b111));
    check("clear_pulses", 32'(pulse_cnt - p0), 32'(1));

    // Asynchronous reset during fault
    raw[6:4] = 3'b101;
    n = 0;
    while (!sensor_fault && n < 40) begin
      step(1);
      n++;
    end
    check("fault_latency2", 32'(n), 32'(14));
    #1 rst_n = 1'b0;
    #1 check("async_rst", 32'(obs), 32'(0));
    raw = '0;
    step(2);
    rst_n = 1'b1;
    step(1);
    check("release_pulse", 32'(change_pulse), 32'(0));
    raw[4] = 1'b1;
    step(10);
    check("restart_lvl", 32'({h, m, l}), 32'(3'b001));
    check("restart_fault", 32'(sensor_fault), 32'(0));

    // Random segments
    repeat (150) begin
      raw = 7'($urandom);
      step(int'($urandom_range(1, 20)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
